// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 64-bit multiply/divide unit for a scalar pipeline.
//
// Operations (op codes from the decoder):
//   15 mul   low XLEN bits of a*b (shift-add)
//   16 div   signed quotient        17 divu unsigned quotient
//   18 rem   signed remainder       19 remu unsigned remainder
// Divide-by-zero and the signed overflow case (MIN / -1) complete on the
// accept edge without iterating. All other operations take XLEN iterations
// and present the result XLEN cycles after the accept cycle.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   in_valid   request present            in_ready  block can accept (IDLE)
//   op         operation code             a, b      rs1 / rs2 operands
//   flush      abort any in-flight operation, no result is produced
//   out_valid  result available (DONE)    out_ready consumer takes result
//   result     operation result, meaningful only while out_valid is high
//   busy       high whenever the unit is not IDLE
module muldiv_seq #(
    parameter int XLEN        = 64,
    parameter int ALUOP_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALUOP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]        a,
    input  logic [XLEN-1:0]        b,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        result,
    output logic                   busy
);

    localparam int CW = $clog2(XLEN);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    // XLEN is a power of two, so the all-ones count is iteration XLEN-1.
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [ALUOP_WIDTH-1:0] OP_MUL  = ALUOP_WIDTH'(5'd15);
    localparam logic [ALUOP_WIDTH-1:0] OP_DIV  = ALUOP_WIDTH'(5'd16);
    localparam logic [ALUOP_WIDTH-1:0] OP_DIVU = ALUOP_WIDTH'(5'd17);
    localparam logic [ALUOP_WIDTH-1:0] OP_REM  = ALUOP_WIDTH'(5'd18);
    localparam logic [ALUOP_WIDTH-1:0] OP_REMU = ALUOP_WIDTH'(5'd19);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Datapath triple shared by both algorithms:
    //   mul: acc = partial product, x = multiplicand (<<), y = multiplier (>>)
    //   div: acc = partial remainder, x = dividend shifting out / quotient
    //        shifting in, y = divisor
    typedef struct packed {
        logic [XLEN-1:0] acc;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
    } dp_t;

    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    // One shift-add or one restoring-division step.
    function automatic dp_t iterate(input logic is_mul, input dp_t s);
        dp_t            n;
        logic [XLEN:0]  rem_shift;
        logic [XLEN:0]  trial;
        rem_shift = {s.acc, s.x[XLEN-1]};
        trial     = rem_shift - {1'b0, s.y};
        if (is_mul) begin
            n.acc = s.acc + (s.y[0] ? s.x : ZERO);
            n.x   = {s.x[XLEN-2:0], 1'b0};
            n.y   = {1'b0, s.y[XLEN-1:1]};
        end else begin
            // A borrow out of the trial subtraction means "restore".
            n.acc = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
            n.x   = {s.x[XLEN-2:0], ~trial[XLEN]};
            n.y   = s.y;
        end
        return n;
    endfunction

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ALUOP_WIDTH-1:0] op_q, op_d;
    logic [XLEN-1:0]        acc_q, acc_d;
    logic [XLEN-1:0]        x_q, x_d;
    logic [XLEN-1:0]        y_q, y_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic [XLEN-1:0]        result_q, result_d;

    logic                   op_valid_s;
    logic                   in_is_mul_s;
    logic                   in_signed_s;
    logic                   in_quot_s;
    logic                   a_neg_s;
    logic                   b_neg_s;
    logic                   q_is_mul_s;
    logic                   q_quot_s;
    logic                   iter_mul_s;
    dp_t                    init_s;
    dp_t                    iter_in_s;
    dp_t                    iter_out_s;
    logic [XLEN-1:0]        fin_s;

    // Next-state, datapath step and result selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        op_valid_s  = (op >= OP_MUL) && (op <= OP_REMU);
        in_is_mul_s = (op == OP_MUL);
        in_signed_s = (op == OP_DIV) || (op == OP_REM);
        in_quot_s   = (op == OP_DIV) || (op == OP_DIVU);
        a_neg_s     = in_signed_s && a[XLEN-1];
        b_neg_s     = in_signed_s && b[XLEN-1];

        init_s.acc = ZERO;
        init_s.x   = a_neg_s ? neg2(a) : a;
        init_s.y   = b_neg_s ? neg2(b) : b;

        q_is_mul_s = (op_q == OP_MUL);
        q_quot_s   = (op_q == OP_DIV) || (op_q == OP_DIVU);

        // Iteration 0 is applied to the freshly loaded operands on the accept
        // edge, so CALC only needs iterations 1..XLEN-1 and the result lands
        // exactly XLEN cycles after the accept cycle.
        iter_in_s  = (state_q == S_IDLE) ? init_s : {acc_q, x_q, y_q};
        iter_mul_s = (state_q == S_IDLE) ? in_is_mul_s : q_is_mul_s;
        iter_out_s = iterate(iter_mul_s, iter_in_s);

        if (q_is_mul_s) begin
            fin_s = iter_out_s.acc;
        end else if (q_quot_s) begin
            fin_s = qneg_q ? neg2(iter_out_s.x) : iter_out_s.x;
        end else begin
            fin_s = rneg_q ? neg2(iter_out_s.acc) : iter_out_s.acc;
        end

        if (flush) begin
            // Abort wins over accept and over the DONE handshake; result kept.
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && op_valid_s) begin
                        op_d   = op;
                        qneg_d = a_neg_s ^ b_neg_s;
                        rneg_d = a_neg_s;
                        if (!in_is_mul_s && (b == ZERO)) begin
                            state_d  = S_DONE;
                            result_d = in_quot_s ? ONES : a;
                        end else if (in_signed_s && (a == MIN_NEG) && (b == ONES)) begin
                            state_d  = S_DONE;
                            result_d = in_quot_s ? a : ZERO;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = CNT_ONE;
                            acc_d   = iter_out_s.acc;
                            x_d     = iter_out_s.x;
                            y_d     = iter_out_s.y;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = iter_out_s.acc;
                    x_d   = iter_out_s.x;
                    y_d   = iter_out_s.y;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_DONE;
                        result_d = fin_s;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            op_q     <= {ALUOP_WIDTH{1'b0}};
            acc_q    <= ZERO;
            x_q      <= ZERO;
            y_q      <= ZERO;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= ZERO;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule
